// File: rtl/roll_step_driver.sv
// Step-strobe source for an up/down rolling counter: walks a shadow count to a
// requested target along the shorter modular path, one strobe per step.
module roll_step_driver #(
   parameter int width_p     = 8,
   parameter int reset_val_p = 0,
   parameter int gap_p       = 0
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] max_val_i,
   input  logic [width_p-1:0] target_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               up_o,
   output logic               down_o,
   output logic [width_p-1:0] count_o,
   output logic               busy_o,
   output logic               done_o
);

   typedef enum logic [1:0] {IDLE, STEP, GAP, DONE} state_e;

   localparam int gap_w_lp = (gap_p > 1) ? $clog2(gap_p) : 1;
   localparam logic [gap_w_lp-1:0] gap_load_lp = (gap_p > 0) ? gap_w_lp'(gap_p - 1) : '0;
   localparam logic [gap_w_lp-1:0] gap_one_lp  = 1;
   localparam logic [width_p-1:0]  one_lp      = 1;
   localparam logic [width_p:0]    one_w_lp    = 1;

   state_e               state_q, state_n;
   logic [width_p-1:0]   count_q, count_n;
   logic [width_p-1:0]   tgt_q, tgt_n;
   logic                 dir_up_q, dir_up_n;
   logic [gap_w_lp-1:0]  gap_cnt_q, gap_cnt_n;

   logic [width_p-1:0]   tgt_clamped;
   logic [width_p-1:0]   count_step;
   logic [width_p:0]     modulus, fwd, bwd;

   // Distances are taken one bit wider so tgt + M - count cannot overflow.
   always_comb begin
      tgt_clamped = (target_i > max_val_i) ? max_val_i : target_i;
      modulus     = {1'b0, max_val_i} + one_w_lp;
      fwd = (tgt_clamped >= count_q) ? ({1'b0, tgt_clamped} - {1'b0, count_q})
                                     : ({1'b0, tgt_clamped} + modulus - {1'b0, count_q});
      bwd = (count_q >= tgt_clamped) ? ({1'b0, count_q} - {1'b0, tgt_clamped})
                                     : ({1'b0, count_q} + modulus - {1'b0, tgt_clamped});
      if (dir_up_q) count_step = (count_q == max_val_i) ? '0 : count_q + one_lp;
      else          count_step = (count_q == '0) ? max_val_i : count_q - one_lp;
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      state_n   = state_q;
      count_n   = count_q;
      tgt_n     = tgt_q;
      dir_up_n  = dir_up_q;
      gap_cnt_n = gap_cnt_q;
      ready_o   = 1'b0;
      up_o      = 1'b0;
      down_o    = 1'b0;
      busy_o    = 1'b1;
      done_o    = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            busy_o  = 1'b0;
            if (valid_i) begin
               tgt_n    = tgt_clamped;
               dir_up_n = (fwd <= bwd);
               state_n  = (tgt_clamped == count_q) ? DONE : STEP;
            end
         end
         STEP: begin
            up_o    = dir_up_q;
            down_o  = ~dir_up_q;
            count_n = count_step;
            if (count_step == tgt_q) begin
               state_n = DONE;
            end else if (gap_p > 0) begin
               state_n   = GAP;
               gap_cnt_n = gap_load_lp;
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) state_n = STEP;
            else                 gap_cnt_n = gap_cnt_q - gap_one_lp;
         end
         DONE: begin
            done_o  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         count_q <= width_p'(reset_val_p);
      end else begin
         state_q <= state_n;
         count_q <= count_n;
      end
   end

   // NOTE: command registers need no reset; they are always loaded on accept before use.
   always_ff @(posedge clk_i) begin
      tgt_q     <= tgt_n;
      dir_up_q  <= dir_up_n;
      gap_cnt_q <= gap_cnt_n;
   end

   assign count_o = count_q;

endmodule

// File: tb/tb_roll_step_driver.sv
// Bench for roll_step_driver: directed cases plus random commands on a gap=0 and
// a gap=2 instance, checked against a modular-arithmetic model and a strobe-fed counter.
module tb_roll_step_driver;

   localparam int W  = 8;
   localparam int RV = 0;
   localparam int G0 = 0;
   localparam int G1 = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  max_s[2], target_s[2], count_s[2];
   logic          valid_s[2], ready_s[2], up_s[2], down_s[2], busy_s[2], done_s[2];

   int tests = 0;
   int fails = 0;
   int model_cnt[2];
   int ref_cnt[2];
   bit sb_en = 1'b0;

   always #5 clk = ~clk;

   roll_step_driver #(.width_p(W), .reset_val_p(RV), .gap_p(G0)) dut_g0 (
      .clk_i(clk), .reset_i(reset), .max_val_i(max_s[0]), .target_i(target_s[0]),
      .valid_i(valid_s[0]), .ready_o(ready_s[0]), .up_o(up_s[0]), .down_o(down_s[0]),
      .count_o(count_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]));

   roll_step_driver #(.width_p(W), .reset_val_p(RV), .gap_p(G1)) dut_g2 (
      .clk_i(clk), .reset_i(reset), .max_val_i(max_s[1]), .target_i(target_s[1]),
      .valid_i(valid_s[1]), .ready_o(ready_s[1]), .up_o(up_s[1]), .down_o(down_s[1]),
      .count_o(count_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]));

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int gap_of(input int inst);
      return (inst == 0) ? G0 : G1;
   endfunction

   // Reference rolling counter driven only by the strobes.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset)          ref_cnt[i] <= RV;
         else if (up_s[i])   ref_cnt[i] <= (ref_cnt[i] == int'(max_s[i])) ? 0 : ref_cnt[i] + 1;
         else if (down_s[i]) ref_cnt[i] <= (ref_cnt[i] == 0) ? int'(max_s[i]) : ref_cnt[i] - 1;
      end
   end

   always @(negedge clk) begin
      if (sb_en) begin
         for (int i = 0; i < 2; i++) begin
            check("sb_count", int'(count_s[i]), ref_cnt[i]);
            check("one_hot", int'(up_s[i] & down_s[i]), 0);
         end
      end
   end

   // Issues one command and checks every strobe, the done timing and the final count.
   task automatic run_cmd(input int inst, input int tgt_raw, input int mx, input int hold_tgt,
                          output int n_up, output int n_down, output int done_cyc);
      int m, t, c, fwd, bwd, n, g, exp_done;
      bit go_up;
      g        = gap_of(inst);
      m        = mx + 1;
      t        = (tgt_raw > mx) ? mx : tgt_raw;
      c        = model_cnt[inst];
      fwd      = (t - c + m) % m;
      bwd      = (c - t + m) % m;
      go_up    = (fwd <= bwd);
      n        = go_up ? fwd : bwd;
      exp_done = (n == 0) ? 1 : 1 + n * (g + 1) - g;
      n_up     = 0;
      n_down   = 0;
      done_cyc = -1;
      @(negedge clk);
      check("ready_idle", int'(ready_s[inst]), 1);
      max_s[inst]    = W'(mx);
      target_s[inst] = W'(tgt_raw);
      valid_s[inst]  = 1'b1;
      for (int cyc = 1; cyc <= exp_done + 8; cyc++) begin
         @(negedge clk);
         if (hold_tgt < 0) valid_s[inst] = 1'b0;
         else              target_s[inst] = W'(hold_tgt);
         if (up_s[inst] || down_s[inst]) begin
            check("strobe_dir", int'(up_s[inst]), int'(go_up));
            check("strobe_cycle", cyc, 1 + (n_up + n_down) * (g + 1));
            if (up_s[inst]) n_up++;
            else            n_down++;
         end
         check("busy", int'(busy_s[inst]), 1);
         check("ready_busy", int'(ready_s[inst]), 0);
         if (done_s[inst]) begin
            done_cyc = cyc;
            break;
         end
      end
      valid_s[inst] = 1'b0;
      check("done_cycle", done_cyc, exp_done);
      check("strobes", n_up + n_down, n);
      check("final_count", int'(count_s[inst]), t);
      model_cnt[inst] = t;
      @(negedge clk);
      check("ready_after", int'(ready_s[inst]), 1);
      check("done_pulse", int'(done_s[inst]), 0);
      check("count_after", int'(count_s[inst]), t);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int nu, nd, dc, c, mx, tg;
      for (int i = 0; i < 2; i++) begin
         valid_s[i]  = 1'b0;
         max_s[i]    = '0;
         target_s[i] = '0;
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_count", int'(count_s[i]), 0);
         check("rst_ready", int'(ready_s[i]), 1);
         check("rst_busy", int'(busy_s[i]), 0);
         check("rst_up", int'(up_s[i]), 0);
         check("rst_down", int'(down_s[i]), 0);
         check("rst_done", int'(done_s[i]), 0);
         model_cnt[i] = RV;
      end
      reset = 1'b0;
      sb_en = 1'b1;

      run_cmd(0, 3, 9, -1, nu, nd, dc);
      check("fwd_up", nu, 3);
      check("fwd_down", nd, 0);
      check("fwd_done", dc, 4);
      run_cmd(0, 1, 9, -1, nu, nd, dc);
      run_cmd(0, 8, 9, -1, nu, nd, dc);
      check("wrap_down", nd, 3);
      check("wrap_up", nu, 0);
      check("wrap_done", dc, 4);
      run_cmd(0, 3, 9, -1, nu, nd, dc);
      run_cmd(0, 8, 9, -1, nu, nd, dc);
      check("tie_up", nu, 5);
      check("tie_done", dc, 6);
      run_cmd(0, 12, 9, -1, nu, nd, dc);
      check("clamp_up", nu, 1);
      check("clamp_count", int'(count_s[0]), 9);
      run_cmd(0, 9, 9, -1, nu, nd, dc);
      check("zero_strobes", nu + nd, 0);
      check("zero_done", dc, 1);
      run_cmd(0, 5, 9, 0, nu, nd, dc);
      check("hold_down", nd, 4);
      check("hold_done", dc, 5);
      run_cmd(0, 0, 9, -1, nu, nd, dc);
      run_cmd(0, 200, 0, -1, nu, nd, dc);
      check("max0_strobes", nu + nd, 0);
      check("max0_done", dc, 1);
      run_cmd(1, 2, 15, -1, nu, nd, dc);
      check("gap_up", nu, 2);
      check("gap_done", dc, 5);

      // Reset in the middle of a command.
      @(negedge clk);
      max_s[0]    = W'(9);
      target_s[0] = W'(5);
      valid_s[0]  = 1'b1;
      @(negedge clk);
      valid_s[0] = 1'b0;
      check("mid_up1", int'(up_s[0]), 1);
      @(negedge clk);
      check("mid_up2", int'(up_s[0]), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_up", int'(up_s[0]), 0);
      check("mid_rst_down", int'(down_s[0]), 0);
      check("mid_rst_count", int'(count_s[0]), 0);
      check("mid_rst_ready", int'(ready_s[0]), 1);
      check("mid_rst_busy", int'(busy_s[0]), 0);
      model_cnt[0] = RV;
      model_cnt[1] = RV;
      @(negedge clk);
      check("post_rst_up", int'(up_s[0]), 0);
      check("post_rst_count", int'(count_s[0]), 0);

      for (int inst = 0; inst < 2; inst++) begin
         for (int k = 0; k < 200; k++) begin
            c  = model_cnt[inst];
            mx = c + int'($urandom_range(0, 63 - c));
            tg = ($urandom_range(0, 7) == 0) ? c : int'($urandom_range(0, 80));
            run_cmd(inst, tg, mx, -1, nu, nd, dc);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/roll_step_driver.md
Name: roll_step_driver

Overview:
Command-driven source of up/down step strobes for an up/down rolling counter (wraps max->0 on up, 0->max on down). Accepts a target count over a valid/ready handshake. Emits single-cycle up or down strobes along the shorter modular path until its shadow count equals the target, then pulses done. The shadow count tracks a downstream rolling counter that shares its clock, reset, reset value and max value.

Parameters:
width_p, 8, width of count, target and max values
reset_val_p, 0, shadow count value after reset; must match the downstream counter's reset value
gap_p, 0, idle cycles inserted between consecutive strobes (0 = one strobe per cycle)

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
max_val_i  input  width_p  wrap point; count range 0..max_val_i; must be stable while busy_o=1
target_i  input  width_p  requested count; sampled on handshake
valid_i  input  1  command valid
ready_o  output  1  command accept; high only in IDLE
up_o  output  1  increment strobe to downstream counter
down_o  output  1  decrement strobe to downstream counter
count_o  output  width_p  shadow count; equals downstream count after each strobe
busy_o  output  1  high in STEP, GAP and DONE
done_o  output  1  one-cycle pulse when target is reached

Behaviour:
- Reset: the clock edge with reset_i=1 forces state IDLE and count_o=reset_val_p. Outputs after that edge: ready_o=1, up_o=0, down_o=0, busy_o=0, done_o=0. Reset overrides any in-flight command; no further strobes are issued for it.
- Handshake: accept when valid_i&&ready_o at a rising edge. Latch tgt = min(target_i, max_val_i), i.e. clamp out-of-range targets to max. valid_i while ready_o=0 is ignored; nothing is queued.
- Direction on accept, computed in width_p+1 bits with modulus M = max_val_i+1:
  - fwd = (tgt - count) mod M
  - bwd = (count - tgt) mod M
  - fwd <= bwd selects up, otherwise down. A tie selects up.
- States:
  - IDLE: ready_o=1. On accept, go to DONE if tgt==count_o, else go to STEP.
  - STEP (one cycle): exactly one of up_o/down_o=1. At the end of the cycle, count_o updates with the same roll rules as the downstream counter: up gives max->0 else +1; down gives 0->max else -1. If the new count equals tgt, go to DONE. Otherwise go to GAP if gap_p>0, else stay in STEP.
  - GAP: up_o=down_o=0 for exactly gap_p cycles, then STEP.
  - DONE (one cycle): done_o=1, ready_o=0, then IDLE.
- Strobe properties: up_o and down_o are never high together. They are decoded directly from state plus the latched direction bit; no extra pipeline stage.
- Latency: accept at edge 0. First strobe in cycle 1. Strobes repeat every gap_p+1 cycles. done_o occurs in the cycle after the final strobe. A zero-distance command gives done_o in cycle 1 and no strobes.
- Count and timing bounds:
  - Strobe count per command = min(fwd, bwd), which is at most floor(M/2).
  - Total cycles from accept to done_o = 1 + n*(gap_p+1) - gap_p for n>0 strobes.
- max_val_i=0: every target clamps to 0, so every command completes with no strobes.
- Direction is fixed at accept and never re-evaluated mid-command.

Test Plan:
- Reset: hold reset_i 2 cycles -> count_o=0, ready_o=1, busy_o=0, up_o=down_o=done_o=0. Assert reset_i mid-STEP -> strobes stop on the next cycle and count_o=0.
- Forward: max=9, count=0, gap_p=0, target=3 -> up_o high cycles 1-3, count_o 1,2,3, done_o cycle 4, ready_o cycle 5.
- Wrap down: max=9, count=1, target=8 -> fwd=7, bwd=3; down_o ×3, count_o 0,9,8; done_o after the third strobe.
- Tie and clamp:
  - max=9, count=3, target=8 -> 5 up_o strobes, ending at 8.
  - max=9, count=8, target=12 -> clamped to 9; one up_o.
- Zero distance and ignore-while-busy:
  - target==count -> done_o in cycle 1, no strobes.
  - valid_i held during STEP with a different target -> not accepted, ready_o=0.
- Gap, plus scoreboard: gap_p=2, max=15, count=0, target=2 -> up_o in cycles 1 and 4, done_o in cycle 5. Feed up_o/down_o into a reference up/down rolling counter (same max, same reset value) and check its count equals count_o every cycle over 200 random commands.
